// File: rtl/fifo_burst_reader.sv
// Drains the read side of the async FIFO in fixed or timeout-flushed bursts onto a valid/ready stream with sop/eop.
// Latency: trigger edge k -> fifo_rd_en in k+1, m_valid in k+3; m_ready low holds the 2-entry skid and stops reads at 2 outstanding.
module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 15,
  parameter int BURST_LEN   = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic                   busy,
  output logic                   burst_done
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [LEVEL_WIDTH-1:0] BURST_LEN_L = LEVEL_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [LEVEL_WIDTH-1:0] rem, rem_nxt;
  logic [TO_W-1:0]        to_cnt, to_cnt_nxt;
  logic                   first_rd, first_rd_nxt;
  logic                   inflight_vld, inflight_sop, inflight_eop;

  // Skid entries carry {eop, sop, data}.
  logic [DATA_WIDTH+1:0]  skid_dat [2];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             buf_count;
  logic [1:0]             outstanding;

  logic pop, eop_xfer, last_rd, full_trig, part_trig;

  assign m_valid    = (buf_count != 2'd0);
  assign m_data     = skid_dat[rd_ptr][DATA_WIDTH-1:0];
  assign m_sop      = m_valid & skid_dat[rd_ptr][DATA_WIDTH];
  assign m_eop      = m_valid & skid_dat[rd_ptr][DATA_WIDTH+1];
  assign busy       = (state != IDLE);
  assign pop        = m_valid & m_ready;
  assign eop_xfer   = pop & m_eop;
  assign last_rd    = (rem == LEVEL_WIDTH'(1));

  // A word leaving this cycle frees its slot, so reads continue back-to-back at full rate.
  assign outstanding = buf_count - {1'b0, pop} + {1'b0, inflight_vld};

  assign full_trig = (fifo_rd_water_level >= BURST_LEN_L);
  assign part_trig = (TIMEOUT_CYC != 0) && !fifo_rd_empty && (to_cnt == TO_LAST) &&
                     (fifo_rd_water_level != '0);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state        <= IDLE;
      rem          <= '0;
      to_cnt       <= '0;
      first_rd     <= 1'b0;
      inflight_vld <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      buf_count    <= 2'd0;
      burst_done   <= 1'b0;
      for (int i = 0; i < 2; i++) skid_dat[i] <= '0;
    end else begin
      state        <= state_nxt;
      rem          <= rem_nxt;
      to_cnt       <= to_cnt_nxt;
      first_rd     <= first_rd_nxt;
      inflight_vld <= fifo_rd_en;
      inflight_sop <= fifo_rd_en & first_rd;
      inflight_eop <= fifo_rd_en & last_rd;
      if (inflight_vld) begin
        skid_dat[wr_ptr] <= {inflight_eop, inflight_sop, fifo_rd_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_count  <= buf_count + {1'b0, inflight_vld} - {1'b0, pop};
      burst_done <= eop_xfer & (state == DRAIN);
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    first_rd_nxt = first_rd;
    to_cnt_nxt   = '0;
    fifo_rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (full_trig) begin
          rem_nxt      = BURST_LEN_L;
          first_rd_nxt = 1'b1;
          state_nxt    = READ;
        end else if (part_trig) begin
          rem_nxt      = fifo_rd_water_level;
          first_rd_nxt = 1'b1;
          state_nxt    = READ;
        end
        if (fifo_rd_empty || full_trig || part_trig) to_cnt_nxt = '0;
        else if (to_cnt != TO_LAST)                  to_cnt_nxt = to_cnt + TO_W'(1);
        else                                         to_cnt_nxt = to_cnt;
      end
      READ: begin
        fifo_rd_en = (rem != '0) && !fifo_rd_empty && (outstanding < 2'd2);
        if (fifo_rd_en) begin
          rem_nxt      = rem - LEVEL_WIDTH'(1);
          first_rd_nxt = 1'b0;
          if (last_rd) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (eop_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO model and a beat scoreboard.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int LW = 15;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic          m_ready;
  logic          sel;

  logic          a_rd_en, a_valid, a_sop, a_eop, a_busy, a_done;
  logic [DW-1:0] a_data;
  logic          b_rd_en, b_valid, b_sop, b_eop, b_busy, b_done;
  logic [DW-1:0] b_data;
  logic          rd_en, valid, sop, eop, busy, done;
  logic [DW-1:0] data;

  assign rd_en = sel ? b_rd_en : a_rd_en;
  assign valid = sel ? b_valid : a_valid;
  assign sop   = sel ? b_sop   : a_sop;
  assign eop   = sel ? b_eop   : a_eop;
  assign busy  = sel ? b_busy  : a_busy;
  assign done  = sel ? b_done  : a_done;
  assign data  = sel ? b_data  : a_data;

  always #5 rd_clk = ~rd_clk;

  fifo_burst_reader #(.TIMEOUT_CYC(1024)) dut_a (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(a_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
    .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready), .m_sop(a_sop), .m_eop(a_eop),
    .busy(a_busy), .burst_done(a_done));

  fifo_burst_reader #(.TIMEOUT_CYC(16)) dut_b (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(b_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
    .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready), .m_sop(b_sop), .m_eop(b_eop),
    .busy(b_busy), .burst_done(b_done));

  logic [DW-1:0] q[$];
  logic [DW-1:0] pend;
  logic          pend_vld;
  logic [DW+2:0] prev_out;
  logic [DW-1:0] exp_base;
  bit            force_empty, sb_en, prev_stall, rdy_mode;
  int            cyc, errors, checks;
  int            n_rd, n_xfer, n_done, beat, exp_len;
  int            first_vld, sop_cyc, eop_cyc, done_cyc, load;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_rd_empty       = force_empty || (q.size() == 0);
    fifo_rd_water_level = LW'(q.size());
  endtask

  task automatic step();
    @(negedge rd_clk);
    if (sb_en) begin
      if (prev_stall) check("hold", 32'({valid, sop, eop, data}), 32'(prev_out));
      if (rd_en) begin
        check("rd_while_empty", 32'(fifo_rd_empty), 32'(0));
        check("outstanding", 32'((n_rd - n_xfer - ((valid && m_ready) ? 1 : 0)) < 2), 32'(1));
        n_rd++;
      end
      if (valid && first_vld < 0) first_vld = cyc;
      if (valid && m_ready) begin
        check("beat", 32'({sop, eop, data}),
              32'({(beat == 0), (beat == exp_len - 1), 16'(exp_base + 16'(beat))}));
        if (sop) sop_cyc = cyc;
        if (eop) eop_cyc = cyc;
        n_xfer++;
        beat = (beat == exp_len - 1) ? 0 : beat + 1;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    prev_stall = sb_en && valid && !m_ready;
    prev_out   = {valid, sop, eop, data};
    pend_vld   = rd_en && (q.size() > 0);
    if (pend_vld) pend = q.pop_front();
    @(posedge rd_clk);
    #1;
    cyc++;
    if (pend_vld) fifo_rd_data = pend;
    if (rdy_mode) m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    drive_fifo();
  endtask

  task automatic clear_sb();
    n_rd = 0; n_xfer = 0; n_done = 0; beat = 0;
    first_vld = -1; sop_cyc = -1; eop_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    rd_rst = 1'b1;
    q.delete();
    force_empty = 1'b0;
    rdy_mode = 1'b0;
    m_ready = 1'b1;
    drive_fifo();
    repeat (2) step();
    rd_rst = 1'b0;
    clear_sb();
    sb_en = 1'b1;
  endtask

  task automatic load_words(input logic [DW-1:0] base, input int n, input int len);
    for (int i = 0; i < n; i++) q.push_back(16'(base + 16'(i)));
    exp_base = base;
    exp_len  = len;
    load     = cyc;
    drive_fifo();
  endtask

  task automatic run_burst(input string tag, input int budget);
    int start;
    int i;
    start = n_done;
    i = 0;
    while (n_done == start && i < budget) begin
      step();
      i++;
    end
    check({tag, "_done"}, 32'(n_done - start), 32'(1));
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    sel = 1'b0; rd_rst = 1'b1; m_ready = 1'b1; fifo_rd_data = '0;
    pend = '0; pend_vld = 1'b0; prev_out = '0; exp_base = '0; exp_len = 1; load = 0;
    clear_sb();
    do_reset();
    check("reset_a", 32'({a_rd_en, a_valid, a_sop, a_eop, a_busy, a_done, a_data}), 32'(0));
    check("reset_b", 32'({b_rd_en, b_valid, b_sop, b_eop, b_busy, b_done, b_data}), 32'(0));

    // Full burst, downstream always ready.
    load_words(16'h0000, 256, 256);
    run_burst("t1", 400);
    repeat (5) step();
    check("t1_vld_latency", 32'(first_vld - load), 32'(3));
    check("t1_xfers", 32'(n_xfer), 32'(256));
    check("t1_sop_to_eop", 32'(eop_cyc - sop_cyc), 32'(255));
    check("t1_done_after_eop", 32'(done_cyc - eop_cyc), 32'(1));
    check("t1_done_cnt", 32'(n_done), 32'(1));
    check("t1_idle", 32'({busy, valid, rd_en}), 32'(0));

    // Full burst out of 300 words with 1,0,0,1 backpressure.
    do_reset();
    rdy_mode = 1'b1;
    m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    load_words(16'h0200, 300, 256);
    run_burst("t2", 1500);
    check("t2_xfers", 32'(n_xfer), 32'(256));
    check("t2_reads", 32'(n_rd), 32'(256));
    check("t2_left", 32'(q.size()), 32'(44));

    // Partial burst of 5 after the 1024-cycle timeout.
    do_reset();
    load_words(16'h0500, 5, 5);
    run_burst("t3", 1200);
    check("t3_not_early", 32'(first_vld - load >= 1026), 32'(1));
    check("t3_not_late", 32'(first_vld - load <= 1027), 32'(1));
    check("t3_xfers", 32'(n_xfer), 32'(5));
    check("t3_fifo_empty", 32'(q.size()), 32'(0));

    // Single-word burst with a 16-cycle timeout.
    do_reset();
    sel = 1'b1;
    load_words(16'h0777, 1, 1);
    run_burst("t4", 200);
    repeat (60) step();
    check("t4_not_early", 32'(first_vld - load >= 18), 32'(1));
    check("t4_not_late", 32'(first_vld - load <= 19), 32'(1));
    check("t4_sop_eop_same", 32'(sop_cyc == eop_cyc && sop_cyc >= 0), 32'(1));
    check("t4_reads", 32'(n_rd), 32'(1));
    check("t4_xfers", 32'(n_xfer), 32'(1));
    sel = 1'b0;

    // Level says 300 but the FIFO reports empty: no reads until empty clears.
    do_reset();
    force_empty = 1'b1;
    load_words(16'h0300, 300, 256);
    repeat (40) step();
    check("t5_no_rd", 32'(n_rd), 32'(0));
    check("t5_busy_hold", 32'({busy, valid}), 32'(2));
    force_empty = 1'b0;
    drive_fifo();
    run_burst("t5", 600);
    check("t5_xfers", 32'(n_xfer), 32'(256));
    check("t5_left", 32'(q.size()), 32'(44));

    // Reset after 100 beats, then a clean burst from a freshly reset FIFO.
    do_reset();
    load_words(16'h0400, 256, 256);
    for (int i = 0; i < 300 && n_xfer < 100; i++) step();
    check("t6_reach100", 32'(n_xfer), 32'(100));
    sb_en = 1'b0;
    m_ready = 1'b0;
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    check("t6_rst_out", 32'({valid, busy, rd_en, sop, eop, done}), 32'(0));
    check("t6_rst_state", 32'(dut_a.state == dut_a.IDLE), 32'(1));
    q.delete();
    m_ready = 1'b1;
    drive_fifo();
    clear_sb();
    sb_en = 1'b1;
    repeat (4) step();
    check("t6_no_stale", 32'(n_xfer + n_rd), 32'(0));
    load_words(16'h0600, 256, 256);
    run_burst("t6", 400);
    check("t6_vld_latency", 32'(first_vld - load), 32'(3));
    check("t6_xfers", 32'(n_xfer), 32'(256));
    check("t6_sop_to_eop", 32'(eop_cyc - sop_cyc), 32'(255));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
